// File: rtl/zeroriscy_defines.sv
// Core-wide RV32 opcode constants shared by zero-riscy decode, tracer and profiler.
package zeroriscy_defines;

  localparam logic [6:0] OPCODE_SYSTEM = 7'h73;
  localparam logic [6:0] OPCODE_FENCE  = 7'h0f;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;

endpackage

// File: rtl/zeroriscy_instr_profiler_pkg.sv
// Profiler types: instruction classes, classification constants and trace record.
package zeroriscy_profiler_defines;
  import zeroriscy_defines::*;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_JUMP   = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_MULDIV = 3'd5,
    CLS_SYSTEM = 3'd6,
    CLS_OTHER  = 3'd7
  } prof_class_e;

  localparam logic [6:0] FUNCT7_MULDIV   = 7'b0000001;
  localparam logic [2:0] FUNCT3_JALR     = 3'b000;
  localparam logic [2:0] FUNCT3_PRIV     = 3'b000;
  localparam logic [2:0] FUNCT3_SYS_RSVD = 3'b100;

  // Privileged instructions are matched on the whole word (funct3 = 000 space).
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

  // 'class' is a reserved word, so the class field is named iclass.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    prof_class_e iclass;
  } trace_rec_t;

endpackage

// File: rtl/zeroriscy_instr_classifier.sv
// Combinational instruction-to-class decoder, shared with the tracer.
module zeroriscy_instr_classifier
  import zeroriscy_defines::*;
  import zeroriscy_profiler_defines::*;
(
  input  logic [31:0] instr_i,
  output prof_class_e class_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_priv;

  assign w_opcode  = instr_i[6:0];
  assign w_funct3  = instr_i[14:12];
  assign w_funct7  = instr_i[31:25];
  assign w_is_priv = (instr_i == INSTR_ECALL) || (instr_i == INSTR_EBREAK) ||
                     (instr_i == INSTR_MRET)  || (instr_i == INSTR_WFI);

  // Decode opcode plus funct fields into a class; unmatched encodings fall to OTHER
  always_comb begin
    class_o = CLS_OTHER;
    case (w_opcode)
      OPCODE_OP: begin
        if (w_funct7 == FUNCT7_MULDIV) begin
          class_o = CLS_MULDIV;
        end else begin
          class_o = CLS_ALU;
        end
      end
      OPCODE_OPIMM, OPCODE_LUI, OPCODE_AUIPC: class_o = CLS_ALU;
      OPCODE_JAL:    class_o = CLS_JUMP;
      OPCODE_JALR: begin
        if (w_funct3 == FUNCT3_JALR) begin
          class_o = CLS_JUMP;
        end else begin
          class_o = CLS_OTHER;
        end
      end
      OPCODE_BRANCH: class_o = CLS_BRANCH;
      OPCODE_LOAD:   class_o = CLS_LOAD;
      OPCODE_STORE:  class_o = CLS_STORE;
      OPCODE_SYSTEM: begin
        if (w_funct3 == FUNCT3_PRIV) begin
          if (w_is_priv) begin
            class_o = CLS_SYSTEM;
          end else begin
            class_o = CLS_OTHER;
          end
        end else if (w_funct3 == FUNCT3_SYS_RSVD) begin
          class_o = CLS_OTHER;
        end else begin
          class_o = CLS_SYSTEM;
        end
      end
      default: class_o = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/zeroriscy_instr_profiler.sv
// Retire-side profiler: per-class saturating counters plus a trace FIFO of retired instructions.
module zeroriscy_instr_profiler
  import zeroriscy_profiler_defines::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  retire_valid_i,
  input  logic [31:0]           retire_instr_i,
  input  logic [31:0]           retire_pc_i,
  input  logic                  clear_i,
  input  logic                  freeze_i,
  input  logic                  trace_en_i,
  input  logic [2:0]            cnt_sel_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic [7:0]            cnt_sat_o,
  output logic                  trace_valid_o,
  input  logic                  trace_ready_i,
  output logic [31:0]           trace_pc_o,
  output logic [31:0]           trace_instr_o,
  output logic [2:0]            trace_class_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  prof_class_e                  w_class;
  logic [2:0]                   w_cls_idx;
  logic                         w_count_en;
  logic [7:0][CNT_WIDTH-1:0]    r_cnt;
  logic [7:0]                   r_sat;
  logic [CNT_WIDTH-1:0]         r_cnt_rd;
  logic [DROP_WIDTH-1:0]        r_drop;

  trace_rec_t [FIFO_DEPTH-1:0]  r_mem;
  logic [PW-1:0]                r_wr_ptr;
  logic [PW-1:0]                r_rd_ptr;
  trace_rec_t                   w_rec;
  trace_rec_t                   w_head;
  logic                         w_empty;
  logic                         w_full;
  logic                         w_push_req;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_drop;

  zeroriscy_instr_classifier u_classifier (
    .instr_i (retire_instr_i),
    .class_o (w_class)
  );

  assign w_cls_idx  = w_class;
  assign w_count_en = retire_valid_i && !freeze_i;

  // FIFO status: the wrap bit distinguishes full from empty when addresses match
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = !w_empty && trace_ready_i;
  assign w_push_req = retire_valid_i && trace_en_i;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_rec.pc     = retire_pc_i;
  assign w_rec.instr  = retire_instr_i;
  assign w_rec.iclass = w_class;
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];

  // Per-class saturating counters and sticky saturation flags; clear wins over retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 8'h00;
    end else if (clear_i) begin
      r_cnt <= '0;
      r_sat <= 8'h00;
    end else if (w_count_en) begin
      if (r_cnt[w_cls_idx] == {CNT_WIDTH{1'b1}}) begin
        r_sat[w_cls_idx] <= 1'b1;
      end else begin
        r_cnt[w_cls_idx] <= r_cnt[w_cls_idx] + CNT_WIDTH'(1);
      end
    end
  end

  // Registered read port for the selected class counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_rd <= '0;
    end else begin
      r_cnt_rd <= r_cnt[cnt_sel_i];
    end
  end

  // Saturating count of trace records lost to a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (clear_i) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != {DROP_WIDTH{1'b1}})) begin
      r_drop <= r_drop + DROP_WIDTH'(1);
    end
  end

  // Trace storage write; contents are zeroed on reset so the head reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
    end
  end

  // Write and read pointers with wrap bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  assign cnt_o         = r_cnt_rd;
  assign cnt_sat_o     = r_sat;
  assign drop_cnt_o    = r_drop;
  assign trace_valid_o = !w_empty;
  assign trace_pc_o    = w_head.pc;
  assign trace_instr_o = w_head.instr;
  assign trace_class_o = w_head.iclass;

endmodule

// File: tb/tb_zeroriscy_instr_profiler.sv
// Directed scoreboard bench for zeroriscy_instr_profiler (CNT_WIDTH=4 to reach saturation).
module tb_zeroriscy_instr_profiler;

  localparam int CW = 4;
  localparam int FD = 8;
  localparam int DW = 16;

  localparam logic [31:0] I_ADDI   = 32'h0010_0093;
  localparam logic [31:0] I_MUL    = 32'h0220_8033;
  localparam logic [31:0] I_DIV    = 32'h0220_C033;
  localparam logic [31:0] I_CSRRW  = 32'h3052_9073;
  localparam logic [31:0] I_LW     = 32'h0000_A103;
  localparam logic [31:0] I_SW     = 32'h0020_A023;
  localparam logic [31:0] I_BEQ    = 32'h0020_8463;
  localparam logic [31:0] I_JAL    = 32'h0080_006F;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;
  localparam logic [31:0] I_CUST   = 32'h0000_000B;
  localparam logic [31:0] I_JALR1  = 32'h0000_9067;
  localparam logic [31:0] I_LUI    = 32'h0000_10B7;
  localparam logic [31:0] I_AUIPC  = 32'h0000_1097;
  localparam logic [31:0] I_FENCE  = 32'h0000_000F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          retire_valid_i = 1'b0;
  logic [31:0]   retire_instr_i = 32'h0;
  logic [31:0]   retire_pc_i = 32'h0;
  logic          clear_i = 1'b0;
  logic          freeze_i = 1'b0;
  logic          trace_en_i = 1'b1;
  logic [2:0]    cnt_sel_i = 3'd0;
  logic [CW-1:0] cnt_o;
  logic [7:0]    cnt_sat_o;
  logic          trace_valid_o;
  logic          trace_ready_i = 1'b1;
  logic [31:0]   trace_pc_o;
  logic [31:0]   trace_instr_o;
  logic [2:0]    trace_class_o;
  logic [DW-1:0] drop_cnt_o;

  int            n_chk = 0;
  int            n_err = 0;
  logic [66:0]   sb_q[$];
  logic [66:0]   mon_exp;

  zeroriscy_instr_profiler #(
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (FD),
    .DROP_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .retire_valid_i (retire_valid_i),
    .retire_instr_i (retire_instr_i),
    .retire_pc_i    (retire_pc_i),
    .clear_i        (clear_i),
    .freeze_i       (freeze_i),
    .trace_en_i     (trace_en_i),
    .cnt_sel_i      (cnt_sel_i),
    .cnt_o          (cnt_o),
    .cnt_sat_o      (cnt_sat_o),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_pc_o     (trace_pc_o),
    .trace_instr_o  (trace_instr_o),
    .trace_class_o  (trace_class_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [66:0] got, input logic [66:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every accepted trace handshake is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && trace_valid_o && trace_ready_i) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL trace_unexpected: got %0h expected no record",
                 {trace_pc_o, trace_instr_o, trace_class_o});
      end else begin
        mon_exp = sb_q.pop_front();
        check("trace_rec", {trace_pc_o, trace_instr_o, trace_class_o}, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    retire_valid_i = 1'b0;
    retire_instr_i = 32'h0;
    retire_pc_i = 32'h0;
    clear_i = 1'b0;
    freeze_i = 1'b0;
    trace_en_i = 1'b1;
    cnt_sel_i = 3'd0;
    trace_ready_i = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One retire this cycle; the expected trace record is queued when a push is expected
  task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [2:0] cls, input bit exp_push);
    retire_valid_i = 1'b1;
    retire_pc_i = pc;
    retire_instr_i = instr;
    if (exp_push) sb_q.push_back({pc, instr, cls});
    @(posedge clk);
    #1;
    retire_valid_i = 1'b0;
  endtask

  task automatic read_cnt(input logic [2:0] sel, input logic [CW-1:0] exp);
    cnt_sel_i = sel;
    @(posedge clk);
    #1;
    check($sformatf("cnt%0d", sel), cnt_o, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_cnt", cnt_o, 0);
    check("rst_sat", cnt_sat_o, 0);
    check("rst_valid", trace_valid_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_head", {trace_pc_o, trace_instr_o, trace_class_o}, 0);

    // ADDI at 0x80: counter latency, no fall-through, stable head under backpressure
    trace_ready_i = 1'b0;
    retire(32'h80, I_ADDI, 3'd0, 1'b1);
    check("t1_valid_n1", trace_valid_o, 1);
    check("t1_cnt_n1", cnt_o, 0);
    idle(1);
    check("t1_cnt_n2", cnt_o, 1);
    idle(2);
    check("t1_head_hold", {trace_valid_o, trace_pc_o, trace_instr_o, trace_class_o},
          {1'b1, 32'h80, I_ADDI, 3'd0});
    trace_ready_i = 1'b1;
    idle(1);
    check("t1_drained", trace_valid_o, 0);

    // MULDIV and SYSTEM counting
    do_reset();
    retire(32'h100, I_MUL, 3'd5, 1'b1);
    retire(32'h104, I_DIV, 3'd5, 1'b1);
    retire(32'h108, I_CSRRW, 3'd6, 1'b1);
    read_cnt(3'd5, 2);
    read_cnt(3'd6, 1);
    read_cnt(3'd0, 0);

    // Overflow: FD+3 retires with no consumer
    do_reset();
    trace_ready_i = 1'b0;
    for (int i = 0; i < FD + 3; i++) begin
      if (i % 2 == 0) retire(32'h1000 + 32'(i * 4), I_LW, 3'd3, i < FD);
      else            retire(32'h1000 + 32'(i * 4), I_SW, 3'd4, i < FD);
    end
    check("t3_drop3", drop_cnt_o, 3);
    check("t3_valid", trace_valid_o, 1);
    // Full FIFO with simultaneous pop and push
    trace_ready_i = 1'b1;
    retire(32'h2000, I_MUL, 3'd5, 1'b1);
    trace_ready_i = 1'b0;
    check("t3_drop_same", drop_cnt_o, 3);
    retire(32'h2004, I_ADDI, 3'd0, 1'b0);
    check("t3_still_full", drop_cnt_o, 4);
    trace_ready_i = 1'b1;
    idle(FD + 4);
    check("t3_empty", trace_valid_o, 0);
    check("t3_sb_empty", sb_q.size(), 0);

    // Saturation at CNT_WIDTH=4, then clear against a same-cycle retire
    do_reset();
    for (int i = 0; i < 17; i++) retire(32'h3000 + 32'(i * 4), I_ADDI, 3'd0, 1'b1);
    read_cnt(3'd0, 15);
    check("t5_sat", cnt_sat_o, 8'h01);
    clear_i = 1'b1;
    retire(32'h3100, I_ADDI, 3'd0, 1'b1);
    clear_i = 1'b0;
    read_cnt(3'd0, 0);
    check("t5_sat_clr", cnt_sat_o, 8'h00);
    idle(2);
    check("t5_sb_empty", sb_q.size(), 0);

    // Freeze holds counters but not the trace; class decode spread
    do_reset();
    retire(32'h200, I_BEQ, 3'd2, 1'b1);
    freeze_i = 1'b1;
    for (int i = 0; i < 5; i++) retire(32'h204 + 32'(i * 4), I_BEQ, 3'd2, 1'b1);
    freeze_i = 1'b0;
    retire(32'h300, I_JAL,   3'd1, 1'b1);
    retire(32'h304, I_ECALL, 3'd6, 1'b1);
    retire(32'h308, I_MRET,  3'd6, 1'b1);
    retire(32'h30c, I_CUST,  3'd7, 1'b1);
    retire(32'h310, I_JALR1, 3'd7, 1'b1);
    retire(32'h314, I_LUI,   3'd0, 1'b1);
    retire(32'h318, I_AUIPC, 3'd0, 1'b1);
    retire(32'h31c, I_FENCE, 3'd7, 1'b1);
    trace_en_i = 1'b0;
    retire(32'h320, I_ADDI, 3'd0, 1'b0);
    trace_en_i = 1'b1;
    idle(3);
    read_cnt(3'd2, 1);
    read_cnt(3'd1, 1);
    read_cnt(3'd6, 2);
    read_cnt(3'd7, 3);
    read_cnt(3'd0, 3);
    check("t6_sb_empty", sb_q.size(), 0);

    // Asynchronous reset mid-stream
    trace_ready_i = 1'b0;
    retire(32'h400, I_ADDI, 3'd0, 1'b1);
    retire(32'h404, I_MUL, 3'd5, 1'b1);
    retire(32'h408, I_LW, 3'd3, 1'b1);
    check("t7_pre_valid", trace_valid_o, 1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("t7_rst_valid", trace_valid_o, 0);
    check("t7_rst_cnt", cnt_o, 0);
    check("t7_rst_drop", drop_cnt_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    trace_ready_i = 1'b1;
    for (int s = 0; s < 8; s++) read_cnt(3'(s), 0);
    check("t7_valid_after", trace_valid_o, 0);

    check("final_sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
